// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with exception/ERET squash and PC redirect handshake.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipe_ctrl #(
   parameter int unsigned          ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]    EXC_VECTOR = 32'hBFC00380
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              streq_if,
   input  logic              streq_id,
   input  logic              streq_ex,
   input  logic              streq_mem,
   input  logic              exc_req,
   input  logic              exc_eret,
   input  logic [ADDR_W-1:0] exc_epc,
   input  logic              redir_ready,
   output logic [4:0]        stall,
   output logic [4:0]        flush,
   output logic              redir_valid,
   output logic [ADDR_W-1:0] redir_pc
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {RUN, PEND, REDIR} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_pend_eret;
   logic [ADDR_W-1:0] r_pend_epc;
   logic [ADDR_W-1:0] r_redir_pc;
   logic              w_accept;
   logic              w_sel_eret;
   logic [ADDR_W-1:0] w_sel_epc;

   // A deferred exception (PEND) is accepted from the recorded values once MEM frees up.
   assign w_accept   = !rst && !streq_mem &&
                       ((r_state == RUN && exc_req) || r_state == PEND);
   assign w_sel_eret = (r_state == PEND) ? r_pend_eret : exc_eret;
   assign w_sel_epc  = (r_state == PEND) ? r_pend_epc  : exc_epc;
   assign redir_pc   = r_redir_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         RUN:     if (exc_req) w_next = streq_mem ? PEND : REDIR;
         PEND:    if (!streq_mem) w_next = REDIR;
         REDIR:   if (redir_ready) w_next = RUN;
         default: w_next = RUN;
      endcase
   end

   always_comb begin
      stall       = '0;
      flush       = '0;
      redir_valid = 1'b0;
      if (!rst) begin
         if (r_state == REDIR) begin
            stall       = 5'b00001;
            flush       = 5'b00010;
            redir_valid = 1'b1;
         end else if (w_accept) begin
            flush = 5'b11110;
         end else if (streq_mem) begin
            stall = 5'b01111;
            flush = 5'b10000;
         end else if (streq_ex) begin
            stall = 5'b00111;
            flush = 5'b01000;
         end else if (streq_id) begin
            stall = 5'b00011;
            flush = 5'b00100;
         end else if (streq_if) begin
            stall = 5'b00001;
            flush = 5'b00010;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_eret <= 1'b0;
         r_pend_epc  <= '0;
         r_redir_pc  <= '0;
      end else begin
         if (r_state == RUN && exc_req && streq_mem) begin
            r_pend_eret <= exc_eret;
            r_pend_epc  <= exc_epc;
         end
         if (w_accept) r_redir_pc <= w_sel_eret ? w_sel_epc : EXC_VECTOR;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_stall_cnt <= '0;
         r_perf_flush_cnt <= '0;
      end else begin
         if (stall != '0) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         if (w_accept)    r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_perf_stall_cnt;
   assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected outputs are queued as stimulus is applied
// and popped when the combinational outputs are sampled on the falling edge.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        streq_if, streq_id, streq_ex, streq_mem;
   logic        exc_req, exc_eret, redir_ready;
   logic [31:0] exc_epc;
   logic [4:0]  stall, flush;
   logic        redir_valid;
   logic [31:0] redir_pc;
`ifdef PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   pipe_ctrl #(.ADDR_W(32), .EXC_VECTOR(32'hBFC00380)) dut (
      .clk(clk), .rst(rst),
      .streq_if(streq_if), .streq_id(streq_id), .streq_ex(streq_ex), .streq_mem(streq_mem),
      .exc_req(exc_req), .exc_eret(exc_eret), .exc_epc(exc_epc), .redir_ready(redir_ready),
      .stall(stall), .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc)
`ifdef PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // rq bit order: {mem, ex, id, if}
   typedef struct packed {
      logic [3:0]  rq;
      logic        exc;
      logic        eret;
      logic [31:0] epc;
      logic        rdy;
   } stim_t;

   typedef struct packed {
      logic [4:0]  st;
      logic [4:0]  fl;
      logic        rv;
      logic [31:0] pc;
   } obs_t;

   obs_t   sb[$];
   obs_t   w_obs;
   int     n_tests = 0;
   int     n_fail  = 0;

   assign w_obs = {stall, flush, redir_valid, redir_pc};

   function automatic stim_t S(input logic [3:0] rq, input logic exc, input logic eret,
                               input logic [31:0] epc, input logic rdy);
      return {rq, exc, eret, epc, rdy};
   endfunction

   function automatic obs_t O(input logic [4:0] st, input logic [4:0] fl, input logic rv,
                              input logic [31:0] pc);
      return {st, fl, rv, pc};
   endfunction

   task automatic apply(input stim_t s);
      {streq_mem, streq_ex, streq_id, streq_if} = s.rq;
      exc_req     = s.exc;
      exc_eret    = s.eret;
      exc_epc     = s.epc;
      redir_ready = s.rdy;
   endtask

   task automatic test_reset();
      obs_t e, g;
      rst = 1'b1;
      apply(S(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0));
      #2;
      sb.push_back(O(5'b0, 5'b0, 1'b0, 32'h0));
      g = w_obs; e = sb.pop_front(); n_tests++;
      if (g !== e) begin
         n_fail++; $display("FAIL reset_idle: got %h exp %h", g, e);
      end
      // Requests while reset is held must not leak onto the outputs
      for (int i = 0; i < 2; i++) begin
         apply(S(4'b1111, 1'b1, 1'b0, 32'h0, 1'b0));
         sb.push_back(O(5'b0, 5'b0, 1'b0, 32'h0));
         @(negedge clk);
         g = w_obs; e = sb.pop_front(); n_tests++;
         if (g !== e) begin
            n_fail++; $display("FAIL reset_held[%0d]: got %h exp %h", i, g, e);
         end
      end
      apply(S(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0));
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_stall_ex();
      stim_t s[4];
      obs_t  x[4];
      obs_t  e, g;
      for (int i = 0; i < 3; i++) begin
         s[i] = S(4'b0100, 1'b0, 1'b0, 32'h0, 1'b0);
         x[i] = O(5'b00111, 5'b01000, 1'b0, 32'h0);
      end
      s[3] = S(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
      x[3] = O(5'b00000, 5'b00000, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         apply(s[i]);
         sb.push_back(x[i]);
         @(negedge clk);
         g = w_obs; e = sb.pop_front(); n_tests++;
         if (g !== e) begin
            n_fail++; $display("FAIL stall_ex[%0d]: got %h exp %h", i, g, e);
         end
         n_tests++;
         if ((stall & flush) !== 5'b0) begin
            n_fail++; $display("FAIL stall_and_flush[%0d]: got %b exp 00000", i, stall & flush);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall_priority();
      stim_t s[4];
      obs_t  x[4];
      obs_t  e, g;
      s[0] = S(4'b1010, 1'b0, 1'b0, 32'h0, 1'b0); x[0] = O(5'b01111, 5'b10000, 1'b0, 32'h0);
      s[1] = S(4'b0011, 1'b0, 1'b0, 32'h0, 1'b0); x[1] = O(5'b00011, 5'b00100, 1'b0, 32'h0);
      s[2] = S(4'b0001, 1'b0, 1'b0, 32'h0, 1'b0); x[2] = O(5'b00001, 5'b00010, 1'b0, 32'h0);
      s[3] = S(4'b0110, 1'b0, 1'b0, 32'h0, 1'b0); x[3] = O(5'b00111, 5'b01000, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         apply(s[i]);
         sb.push_back(x[i]);
         @(negedge clk);
         g = w_obs; e = sb.pop_front(); n_tests++;
         if (g !== e) begin
            n_fail++; $display("FAIL stall_prio[%0d]: got %h exp %h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_exception();
      stim_t s[6];
      obs_t  x[6];
      obs_t  e, g;
      s[0] = S(4'b0000, 1'b1, 1'b0, 32'h0,        1'b0); x[0] = O(5'b00000, 5'b11110, 1'b0, 32'h0);
      s[1] = S(4'b0000, 1'b0, 1'b0, 32'h0,        1'b0); x[1] = O(5'b00001, 5'b00010, 1'b1, 32'hBFC00380);
      s[2] = S(4'b0100, 1'b1, 1'b1, 32'h00001234, 1'b0); x[2] = O(5'b00001, 5'b00010, 1'b1, 32'hBFC00380);
      s[3] = S(4'b0000, 1'b0, 1'b0, 32'h0,        1'b1); x[3] = O(5'b00001, 5'b00010, 1'b1, 32'hBFC00380);
      s[4] = S(4'b0000, 1'b0, 1'b0, 32'h0,        1'b0); x[4] = O(5'b00000, 5'b00000, 1'b0, 32'hBFC00380);
      s[5] = S(4'b0001, 1'b0, 1'b0, 32'h0,        1'b0); x[5] = O(5'b00001, 5'b00010, 1'b0, 32'hBFC00380);
      for (int i = 0; i < 6; i++) begin
         apply(s[i]);
         sb.push_back(x[i]);
         @(negedge clk);
         g = w_obs; e = sb.pop_front(); n_tests++;
         if (g !== e) begin
            n_fail++; $display("FAIL exception[%0d]: got %h exp %h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_pend_eret();
      stim_t s[8];
      obs_t  x[8];
      obs_t  e, g;
      s[0] = S(4'b1000, 1'b1, 1'b1, 32'h80001234, 1'b0); x[0] = O(5'b01111, 5'b10000, 1'b0, 32'hBFC00380);
      s[1] = S(4'b1010, 1'b1, 1'b0, 32'h0,        1'b0); x[1] = O(5'b01111, 5'b10000, 1'b0, 32'hBFC00380);
      s[2] = S(4'b1000, 1'b0, 1'b0, 32'h0,        1'b0); x[2] = O(5'b01111, 5'b10000, 1'b0, 32'hBFC00380);
      s[3] = S(4'b1000, 1'b0, 1'b0, 32'h0,        1'b0); x[3] = O(5'b01111, 5'b10000, 1'b0, 32'hBFC00380);
      s[4] = S(4'b0100, 1'b0, 1'b0, 32'h0,        1'b0); x[4] = O(5'b00000, 5'b11110, 1'b0, 32'hBFC00380);
      s[5] = S(4'b0000, 1'b0, 1'b0, 32'h0,        1'b0); x[5] = O(5'b00001, 5'b00010, 1'b1, 32'h80001234);
      s[6] = S(4'b0000, 1'b0, 1'b0, 32'h0,        1'b1); x[6] = O(5'b00001, 5'b00010, 1'b1, 32'h80001234);
      s[7] = S(4'b0000, 1'b0, 1'b0, 32'h0,        1'b0); x[7] = O(5'b00000, 5'b00000, 1'b0, 32'h80001234);
      for (int i = 0; i < 8; i++) begin
         apply(s[i]);
         sb.push_back(x[i]);
         @(negedge clk);
         g = w_obs; e = sb.pop_front(); n_tests++;
         if (g !== e) begin
            n_fail++; $display("FAIL pend_eret[%0d]: got %h exp %h", i, g, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_redir();
      stim_t s[2];
      obs_t  x[2];
      obs_t  e, g;
      s[0] = S(4'b0000, 1'b1, 1'b0, 32'h0, 1'b0); x[0] = O(5'b00000, 5'b11110, 1'b0, 32'h80001234);
      s[1] = S(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0); x[1] = O(5'b00001, 5'b00010, 1'b1, 32'hBFC00380);
      for (int i = 0; i < 2; i++) begin
         apply(s[i]);
         sb.push_back(x[i]);
         @(negedge clk);
         g = w_obs; e = sb.pop_front(); n_tests++;
         if (g !== e) begin
            n_fail++; $display("FAIL reset_redir[%0d]: got %h exp %h", i, g, e);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      sb.push_back(O(5'b0, 5'b0, 1'b0, 32'h0));
      #1;
      g = w_obs; e = sb.pop_front(); n_tests++;
      if (g !== e) begin
         n_fail++; $display("FAIL reset_async: got %h exp %h", g, e);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      sb.push_back(O(5'b0, 5'b0, 1'b0, 32'h0));
      @(negedge clk);
      g = w_obs; e = sb.pop_front(); n_tests++;
      if (g !== e) begin
         n_fail++; $display("FAIL reset_to_run: got %h exp %h", g, e);
      end
      @(posedge clk); #1;
   endtask

`ifdef PERF_CNT_EN
   task automatic test_perf();
      rst = 1'b1;
      apply(S(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         apply(S(4'b0001, 1'b0, 1'b0, 32'h0, 1'b0));
         @(posedge clk); #1;
      end
      apply(S(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0));
      @(negedge clk);
      n_tests++;
      if (perf_stall_cnt !== 32'd5) begin
         n_fail++; $display("FAIL perf_stall5: got %0d exp 5", perf_stall_cnt);
      end
      // Each exception: one accept cycle (stall=0) and one REDIR cycle (stall=00001)
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         apply(S(4'b0000, 1'b1, 1'b0, 32'h0, 1'b0));
         @(posedge clk); #1;
         apply(S(4'b0000, 1'b0, 1'b0, 32'h0, 1'b1));
      end
      @(posedge clk); #1;
      apply(S(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0));
      @(negedge clk);
      n_tests++;
      if (perf_flush_cnt !== 32'd2) begin
         n_fail++; $display("FAIL perf_flush2: got %0d exp 2", perf_flush_cnt);
      end
      n_tests++;
      if (perf_stall_cnt !== 32'd7) begin
         n_fail++; $display("FAIL perf_stall7: got %0d exp 7", perf_stall_cnt);
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_stall_ex();
      test_stall_priority();
      test_exception();
      test_pend_eret();
      test_reset_redir();
`ifdef PERF_CNT_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline: PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Turns per-stage stall requests into per-register hold (stall) and bubble (flush) controls.
- Sequences exception/ERET squash and the PC redirect handshake to the fetch unit.
- All pipeline registers give flush priority over stall, so this block never asserts both on the same register.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for exceptions.
- ADDR_W, 32, width of exc_epc and redir_pc.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- streq_if  in  1  IF stall request (level)
- streq_id  in  1  ID stall request (level, load-use etc.)
- streq_ex  in  1  EX stall request (multi-cycle op)
- streq_mem  in  1  MEM stall request (data access busy)
- exc_req  in  1  single-cycle pulse; instruction in MEM raised exception or ERET
- exc_eret  in  1  qualifies exc_req: 1 = ERET, 0 = exception
- exc_epc  in  ADDR_W  ERET return address, sampled with exc_req
- redir_ready  in  1  fetch unit accepts redirect this cycle
- stall  out  5  hold per register; bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB
- flush  out  5  bubble per register; same bit map
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  ADDR_W  redirect target
- perf_stall_cnt  out  32  stall-cycle count; present only with PERF_CNT_EN
- perf_flush_cnt  out  32  exception flush count; present only with PERF_CNT_EN

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset forces state RUN, clears the pending record, redir_pc = 0, redir_valid = 0, stall = 0, flush = 0. Reset mid-redirect abandons it.
- stall, flush and redir_valid are combinational from state and inputs. The state, pending record and redir_pc are registered.
- FSM states: RUN, PEND, REDIR.

Stall decode (RUN and PEND), deepest request wins:
- streq_mem: stall = 01111, flush = 10000.
- else streq_ex: stall = 00111, flush = 01000.
- else streq_id: stall = 00011, flush = 00100.
- else streq_if: stall = 00001, flush = 00010.
- else stall = 0, flush = 0.
- Invariant: (stall & flush) == 0 in every state and cycle.

RUN:
- exc_req=1 and streq_mem=0: accept.
  - Same cycle: flush = 11110, stall = 00000.
  - Next edge: redir_pc <= exc_eret ? exc_epc : EXC_VECTOR; go to REDIR.
  - Flush overrides all other stall requests.
- exc_req=1 and streq_mem=1: record exc_eret and exc_epc; go to PEND. Stall decode applies this cycle.

PEND:
- stall decode applies while streq_mem=1; further exc_req pulses are ignored (first wins).
- On the first cycle with streq_mem=0: accept using the recorded values, with the same outputs and transition as the RUN acceptance.

REDIR:
- redir_valid = 1; stall = 00001 (PC held); flush = 00010 (no new instruction into ID).
- Other registers flow (they carry bubbles). exc_req is ignored.
- redir_ready=1: go to RUN next edge. redir_valid drops the cycle after the handshake.
- redir_pc is stable for the whole REDIR state.

Other rules:
- redir_valid is 0 outside REDIR.
- An exception and an ERET never coexist; the exc_eret bit alone selects the target.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments each cycle stall != 0.
  - perf_flush_cnt increments on each exception/ERET acceptance.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- streq_ex=1 for 3 cycles, no others -> stall=00111, flush=01000 each of those cycles, then 0/0; stall&flush==0 throughout.
- streq_id=1 and streq_mem=1 together -> stall=01111, flush=10000 (MEM wins).
- exc_req=1, exc_eret=0 in RUN, stalls idle -> same cycle flush=11110; next cycle redir_valid=1, redir_pc=32'hBFC00380, stall=00001, flush=00010. Hold redir_ready=0 for 2 cycles -> all outputs held; redir_ready=1 -> RUN next cycle, redir_valid=0.
- exc_req=1, exc_eret=1, exc_epc=32'h80001234 while streq_mem=1 for 4 cycles; second exc_req pulse (exc_eret=0) during PEND -> stall decode for 4 cycles, then flush=11110; redir_pc=32'h80001234, second pulse ignored.
- exc_req=1 while in REDIR -> ignored; no change to redir_pc or state.
- rst asserted during REDIR -> outputs 0 immediately, state RUN. With PERF_CNT_EN: 5 stall cycles and 2 exceptions give perf_stall_cnt=5, perf_flush_cnt=2; preload 32'hFFFFFFFF wraps to 0.
